// File: rtl/generic_fifo_arb_pkg.sv
// Shared state encoding, default sizing and helpers for the FIFO write arbiter.
package generic_fifo_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_PTR_WIDTH      = 3;
    localparam int DEF_NUM_OF_ENTRIES = 8;
    localparam int DEF_DAT_WIDTH      = 50;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Successor of a requester index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/generic_fifo_wr_arb_if.sv
// Requester-side handshake plus FIFO write-side bus of the write arbiter.
interface generic_fifo_wr_arb_if
    import generic_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH,
    parameter int DAT_WIDTH = DEF_DAT_WIDTH
) ();

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ*DAT_WIDTH-1:0] req_data;
    logic [NUM_REQ*DAT_WIDTH-1:0] req_mask;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         wr_op;
    logic [DAT_WIDTH-1:0]         wr_data;
    logic [DAT_WIDTH-1:0]         wr_mask;
    logic [PTR_WIDTH:0]           wr_entry_used;
    logic                         wr_full_err;

    // Requesters and FIFO status drive in; the arbiter answers.
    modport master (
        output req_valid, req_last, req_data, req_mask, wr_entry_used, wr_full_err,
        input  req_ready, wr_op, wr_data, wr_mask
    );

    modport slave (
        input  req_valid, req_last, req_data, req_mask, wr_entry_used, wr_full_err,
        output req_ready, wr_op, wr_data, wr_mask
    );

endinterface

// File: rtl/generic_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module generic_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] k;

    // Scan upward from ptr and latch onto the first valid bit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        k      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && valid[k]) begin
                found     = 1'b1;
                onehot[k] = 1'b1;
                idx       = k;
            end
        end
    end

endmodule

// File: rtl/generic_fifo_wr_arb.sv
// Packet-aware round-robin arbiter merging NUM_REQ requesters into one FIFO write port.
// A multi-beat packet locks the grant to its owner until the last beat is accepted.
module generic_fifo_wr_arb
    import generic_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int PTR_WIDTH      = DEF_PTR_WIDTH,
    parameter int NUM_OF_ENTRIES = DEF_NUM_OF_ENTRIES,
    parameter int DAT_WIDTH      = DEF_DAT_WIDTH
) (
    input  logic                 clk,
    input  logic                 sreset_n,
    generic_fifo_wr_arb_if.slave bus,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 ovf_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = PTR_WIDTH + 2;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(NUM_OF_ENTRIES);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     sel_idx;
    logic [1:0]           grant_q, grant_d;
    logic                 ovf_q;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic [NUM_REQ-1:0]   ready;
    logic                 xfer;
    logic [CNT_W-1:0]     fill;
    logic                 space_ok;
    logic                 wr_op_p1;
    logic [DAT_WIDTH-1:0] wr_data_p1;
    logic [DAT_WIDTH-1:0] wr_mask_p1;

    generic_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .onehot(pick_onehot),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The write already in flight counts against free space, so a beat is never
    // accepted into the last slot twice.
    assign fill     = CNT_W'(bus.wr_entry_used) + CNT_W'(wr_op_p1);
    assign space_ok = fill < DEPTH;

    // Next-state, grant bookkeeping and the per-requester accept vector.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        ready    = '0;
        xfer     = 1'b0;
        sel_idx  = owner_q;
        if (sreset_n && space_ok) begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        ready   = pick_onehot;
                        xfer    = 1'b1;
                        sel_idx = pick_idx;
                        grant_d = 2'(pick_idx);
                        if (bus.req_last[pick_idx]) begin
                            rr_ptr_d = IDX_W'(rr_next(int'(pick_idx), NUM_REQ));
                        end else begin
                            state_d = LOCK;
                            owner_d = pick_idx;
                        end
                    end
                end
                LOCK: begin
                    ready[owner_q] = 1'b1;
                    if (bus.req_valid[owner_q]) begin
                        xfer = 1'b1;
                        if (bus.req_last[owner_q]) begin
                            state_d  = IDLE;
                            rr_ptr_d = IDX_W'(rr_next(int'(owner_q), NUM_REQ));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control registers: FSM state, round-robin pointer, owner, grant, sticky overflow.
    always_ff @(posedge clk) begin
        if (!sreset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            if (bus.wr_full_err) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Write stage: the accepted beat reaches the FIFO one cycle later; data holds otherwise.
    always_ff @(posedge clk) begin
        if (!sreset_n) begin
            wr_op_p1   <= 1'b0;
            wr_data_p1 <= '0;
            wr_mask_p1 <= '0;
        end else begin
            wr_op_p1 <= xfer;
            if (xfer) begin
                wr_data_p1 <= bus.req_data[int'(sel_idx)*DAT_WIDTH +: DAT_WIDTH];
                wr_mask_p1 <= bus.req_mask[int'(sel_idx)*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.wr_op     = wr_op_p1;
    assign bus.wr_data   = wr_data_p1;
    assign bus.wr_mask   = wr_mask_p1;
    assign grant_id      = grant_q;
    assign busy          = (state_q == LOCK);
    assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_generic_fifo_wr_arb.sv
// Self-checking bench for generic_fifo_wr_arb: directed table, corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_generic_fifo_wr_arb;

    localparam int NR = 4;
    localparam int PW = 3;
    localparam int NE = 8;
    localparam int DW = 50;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] last;
        logic [3:0] used;
        logic [3:0] ready;
        logic       wr_op;
        logic [1:0] grant;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       sreset_n;
    logic [1:0] grant_id;
    logic       busy;
    logic       ovf_err;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner is -1 when no packet is open.
    int             m_owner;
    int             m_rr;
    int             m_grant;
    bit             m_wr_op;
    bit             m_ovf;
    logic [DW-1:0]  m_data;
    logic [DW-1:0]  m_mask;

    generic_fifo_wr_arb_if #(.NUM_REQ(NR), .PTR_WIDTH(PW), .DAT_WIDTH(DW)) bus ();

    generic_fifo_wr_arb #(
        .NUM_REQ       (NR),
        .PTR_WIDTH     (PW),
        .NUM_OF_ENTRIES(NE),
        .DAT_WIDTH     (DW)
    ) dut (
        .clk     (clk),
        .sreset_n(sreset_n),
        .bus     (bus),
        .grant_id(grant_id),
        .busy    (busy),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who may transfer this cycle, from the packet rules.
    function automatic void model_pick(output logic [NR-1:0] rdy, output int win);
        int         occ;
        int         k;
        logic [1:0] o;
        rdy = '0;
        win = -1;
        occ = int'(bus.wr_entry_used) + (m_wr_op ? 1 : 0);
        if (sreset_n !== 1'b1 || occ >= NE) return;
        if (m_owner >= 0) begin
            o   = 2'(m_owner);
            rdy = NR'(1) << m_owner;
            if (bus.req_valid[o]) win = m_owner;
        end else begin
            for (int i = 0; i < NR; i++) begin
                k = (m_rr + i) % NR;
                o = 2'(k);
                if (bus.req_valid[o]) begin
                    win = k;
                    rdy = NR'(1) << k;
                    break;
                end
            end
        end
    endfunction

    task automatic model_step(input int win);
        logic [1:0] w;
        if (sreset_n !== 1'b1) begin
            m_owner = -1; m_rr = 0; m_grant = 0;
            m_wr_op = 1'b0; m_ovf = 1'b0; m_data = '0; m_mask = '0;
            return;
        end
        if (bus.wr_full_err) m_ovf = 1'b1;
        m_wr_op = (win >= 0);
        if (win >= 0) begin
            w       = 2'(win);
            m_data  = bus.req_data[win*DW +: DW];
            m_mask  = bus.req_mask[win*DW +: DW];
            m_grant = win;
            if (bus.req_last[w]) begin
                m_owner = -1;
                m_rr    = (win + 1) % NR;
            end else begin
                m_owner = win;
            end
        end
    endtask

    // One clock: compare everything against the model, cross the edge, advance the model.
    task automatic cycle();
        logic [NR-1:0] rdy;
        int            win;
        #1;
        model_pick(rdy, win);
        chk("req_ready", 64'(bus.req_ready), 64'(rdy));
        chk("wr_op",     64'(bus.wr_op),     64'(m_wr_op));
        chk("wr_data",   64'(bus.wr_data),   64'(m_data));
        chk("wr_mask",   64'(bus.wr_mask),   64'(m_mask));
        chk("grant_id",  64'(grant_id),      64'(m_grant));
        chk("busy",      64'(busy),          64'(m_owner >= 0));
        chk("ovf_err",   64'(ovf_err),       64'(m_ovf));
        @(posedge clk);
        model_step(win);
        #1;
    endtask

    task automatic rand_data();
        logic [63:0] t;
        for (int i = 0; i < NR; i++) begin
            t = {$urandom(), $urandom()};
            bus.req_data[i*DW +: DW] = t[DW-1:0];
            t = {$urandom(), $urandom()};
            bus.req_mask[i*DW +: DW] = t[DW-1:0];
        end
    endtask

    initial begin
        vec_t tbl [18];
        // valid  last    used   ready   wr_op grant busy   (outputs after the edge)
        tbl[0]  = '{4'b1111, 4'b1111, 4'd0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 4'd0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1111, 4'd0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 4'd0, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1111, 4'd0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[5]  = '{4'b0110, 4'b0000, 4'd0, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[6]  = '{4'b0110, 4'b0100, 4'd0, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[7]  = '{4'b0110, 4'b0110, 4'd0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[8]  = '{4'b0100, 4'b0100, 4'd0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[9]  = '{4'b1001, 4'b0000, 4'd0, 4'b1000, 1'b1, 2'd3, 1'b1};
        tbl[10] = '{4'b0001, 4'b0001, 4'd0, 4'b1000, 1'b0, 2'd3, 1'b1};
        tbl[11] = '{4'b0001, 4'b0001, 4'd0, 4'b1000, 1'b0, 2'd3, 1'b1};
        tbl[12] = '{4'b1001, 4'b1000, 4'd0, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 4'd0, 4'b0000, 1'b0, 2'd3, 1'b0};
        tbl[14] = '{4'b0001, 4'b0001, 4'd7, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[15] = '{4'b0001, 4'b0001, 4'd7, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[16] = '{4'b0001, 4'b0001, 4'd8, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[17] = '{4'b0001, 4'b0001, 4'd7, 4'b0001, 1'b1, 2'd0, 1'b0};

        sreset_n          = 1'b0;
        bus.req_valid     = '1;
        bus.req_last      = '1;
        bus.wr_entry_used = '0;
        bus.wr_full_err   = 1'b0;
        rand_data();
        m_owner = -1; m_rr = 0; m_grant = 0;
        m_wr_op = 1'b0; m_ovf = 1'b0; m_data = '0; m_mask = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with every requester asking.
        chk("rst_wr_op", 64'(bus.wr_op), 64'(0));
        chk("rst_busy",  64'(busy),      64'(0));
        cycle();
        sreset_n = 1'b1;

        // Directed table.
        for (int r = 0; r < 18; r++) begin
            bus.req_valid     = tbl[r].valid;
            bus.req_last      = tbl[r].last;
            bus.wr_entry_used = tbl[r].used;
            rand_data();
            #1;
            chk($sformatf("tbl%0d_ready", r), 64'(bus.req_ready), 64'(tbl[r].ready));
            cycle();
            chk($sformatf("tbl%0d_wr_op", r), 64'(bus.wr_op), 64'(tbl[r].wr_op));
            chk($sformatf("tbl%0d_grant", r), 64'(grant_id),  64'(tbl[r].grant));
            chk($sformatf("tbl%0d_busy",  r), 64'(busy),      64'(tbl[r].busy));
        end

        // Overflow flag is sticky.
        bus.wr_entry_used = '0;
        bus.req_valid     = '0;
        bus.wr_full_err   = 1'b1;
        cycle();
        bus.wr_full_err = 1'b0;
        repeat (3) cycle();
        chk("ovf_sticky", 64'(ovf_err), 64'(1));

        // Reset in the middle of a locked packet abandons it.
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0000;
        cycle();
        chk("lock_busy",  64'(busy),     64'(1));
        chk("lock_grant", 64'(grant_id), 64'(2));
        cycle();
        sreset_n = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        cycle();
        chk("midrst_busy",  64'(busy),        64'(0));
        chk("midrst_wr_op", 64'(bus.wr_op),   64'(0));
        chk("midrst_grant", 64'(grant_id),    64'(0));
        chk("midrst_ovf",   64'(ovf_err),     64'(0));
        sreset_n      = 1'b1;
        bus.req_valid = '1;
        bus.req_last  = '1;
        #1;
        chk("post_rst_pick", 64'(bus.req_ready), 64'(4'b0001));
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            bus.req_valid = 4'($urandom());
            if (n % 200 < 100)
                bus.req_last = 4'($urandom()) & 4'($urandom());
            else
                bus.req_last = 4'($urandom()) | 4'($urandom());
            if ($urandom_range(0, 3) == 0)
                bus.wr_entry_used = 4'($urandom_range(6, 8));
            else
                bus.wr_entry_used = 4'($urandom_range(0, 5));
            bus.wr_full_err = ($urandom_range(0, 39) == 0);
            sreset_n        = ($urandom_range(0, 79) != 0);
            rand_data();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/generic_fifo_wr_arb.md
GENERIC_FIFO_WR_ARB -- requirements
Module: generic_fifo_wr_arb

Interface
REQ-001 SHALL have parameters: NUM_REQ, 4, number of requesters; PTR_WIDTH, 3, FIFO pointer width; NUM_OF_ENTRIES, 8, FIFO depth; DAT_WIDTH, 50, data/mask width.
REQ-002 SHALL use one clock and a synchronous active-low reset: clk  input  1  sole clock, all state on rising edge.
REQ-003 sreset_n  input  1  synchronous active-low reset.
REQ-004 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-005 req_last  input  NUM_REQ  per-requester last beat of packet.
REQ-006 req_data  input  NUM_REQ*DAT_WIDTH  packed data, requester i at bits [i*DAT_WIDTH +: DAT_WIDTH].
REQ-007 req_mask  input  NUM_REQ*DAT_WIDTH  packed write mask, same packing.
REQ-008 req_ready  output  NUM_REQ  per-requester accept, combinational.
REQ-009 wr_op  output  1  registered FIFO write strobe.
REQ-010 wr_data  output  DAT_WIDTH  registered FIFO write data.
REQ-011 wr_mask  output  DAT_WIDTH  registered FIFO write mask.
REQ-012 wr_entry_used  input  PTR_WIDTH+1  FIFO write-side occupancy.
REQ-013 wr_full_err  input  1  FIFO write-when-full pulse.
REQ-014 grant_id  output  2  index of current/last packet owner.
REQ-015 busy  output  1  high while in LOCK.
REQ-016 ovf_err  output  1  sticky overflow flag.

Function
REQ-017 Beat transfer SHALL occur on a cycle where req_valid[i] and req_ready[i] are both 1; at most one req_ready bit SHALL be 1 per cycle.
REQ-018 space_ok SHALL be (wr_entry_used + wr_op) < NUM_OF_ENTRIES, computed at PTR_WIDTH+2 bits; when space_ok=0 all req_ready SHALL be 0.
REQ-019 State machine SHALL have states IDLE and LOCK; reset state IDLE.
REQ-020 IDLE: if space_ok and any req_valid, winner = first valid requester scanning from rr_ptr upward modulo NUM_REQ; req_ready[winner]=1 same cycle.
REQ-021 IDLE transfer with req_last=1: stay IDLE, rr_ptr <= (winner+1) mod NUM_REQ, grant_id <= winner.
REQ-022 IDLE transfer with req_last=0: go LOCK, owner <= winner, grant_id <= winner.
REQ-023 LOCK: req_ready SHALL be 1 only for owner, only when space_ok; other requesters SHALL not be served.
REQ-024 LOCK: owner deasserting req_valid mid-packet SHALL hold LOCK with no write (gaps allowed).
REQ-025 LOCK transfer with req_last=1: go IDLE, rr_ptr <= (owner+1) mod NUM_REQ.
REQ-026 Each transfer SHALL produce wr_op=1 with the accepted data/mask exactly one cycle later; no transfer => wr_op=0, wr_data/wr_mask hold.
REQ-027 Back-to-back transfers SHALL sustain one beat per cycle while space_ok holds.
REQ-028 ovf_err SHALL set on wr_full_err=1 and clear only by reset.
REQ-029 busy SHALL equal (state==LOCK).

Reset
REQ-030 On sreset_n=0 at a clock edge: state IDLE, rr_ptr 0, owner 0, wr_op 0, wr_data 0, wr_mask 0, grant_id 0, busy 0, ovf_err 0.
REQ-031 While sreset_n=0, req_ready SHALL be 0; reset mid-packet SHALL abandon the packet with no further writes.

Structure
REQ-032 Shared package generic_fifo_arb_pkg SHALL hold state encoding (IDLE=0, LOCK=1) and default NUM_REQ/DAT_WIDTH constants.
REQ-033 Round-robin pick SHALL be a sub-module generic_rr_pick (valid vector + pointer in, one-hot + index out, combinational).

Verification
REQ-034 All four req_valid=1, single-beat packets, FIFO empty -> grants 0,1,2,3,0 on consecutive cycles, wr_op=1 from cycle 2 onward.
REQ-035 Req1 3-beat packet, req2 valid throughout -> req2 served only after req1 last beat; busy=1 for 2 cycles; grant_id=1 then 2.
REQ-036 wr_entry_used=7, wr_op=0, req0 valid -> one beat accepted, next cycle space_ok=0 (7+1=8), all req_ready=0 until wr_entry_used drops.
REQ-037 Req3 in LOCK drops req_valid 2 cycles mid-packet while req0 valid -> no grant to req0, wr_op=0 for 2 cycles, resume req3.
REQ-038 sreset_n=0 during LOCK -> next cycle state IDLE, busy 0, wr_op 0, rr_ptr 0; wr_full_err pulse -> ovf_err 1 until reset.
